// File: rtl/uart_imem_loader.sv
// UART bootloader: receives a framed program image on RsRx, writes it word by word into
// the instruction memory and holds the CPU in reset until a complete, checksummed image
// has been loaded.
module uart_imem_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 2000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RsRx,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int unsigned BYTES    = DATA_WIDTH / 8;
   localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned ByteIdxW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned TmoW     = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CntW-1:0]     BitEnd   = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]     HalfEnd  = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ByteIdxW-1:0] ByteLast = ByteIdxW'(BYTES - 1);
   localparam logic [TmoW-1:0]     TmoEnd   = TmoW'(TIMEOUT_CLKS - 1);
   localparam logic [16:0]         MaxWords = 17'(2 ** ADDR_WIDTH);

   // Receiver states
   localparam logic [1:0] RxIdle  = 2'd0;
   localparam logic [1:0] RxStart = 2'd1;
   localparam logic [1:0] RxData  = 2'd2;
   localparam logic [1:0] RxStop  = 2'd3;

   // Frame states
   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLenLo = 3'd1;
   localparam logic [2:0] StLenHi = 3'd2;
   localparam logic [2:0] StData  = 3'd3;
   localparam logic [2:0] StCsum  = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;
   localparam logic [2:0] StError = 3'd6;

   // ---------------------------------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------------------------------
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   logic [1:0]      rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            byte_valid_q, byte_valid_d;
   logic            frame_err_q, frame_err_d;

   // Two-flop synchroniser plus one delayed copy for start-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= RsRx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Bit timing: confirm start at half a bit, then sample each bit at its centre
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            if (!rx_sync_q && rx_prev_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         RxStart: begin
            if (rx_cnt_q == HalfEnd) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = RxIdle;  // glitch shorter than half a bit
               end else begin
                  rx_state_d = RxData;
                  rx_bit_d   = '0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == BitEnd) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == BitEnd) begin
               rx_cnt_d   = '0;
               rx_state_d = RxIdle;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
                  rx_byte_d    = rx_shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Receiver state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state_q   <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Frame parser and imem writer
   // ---------------------------------------------------------------------------------------
   logic [2:0]            state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [15:0]           word_cnt_q, word_cnt_d;
   logic [ByteIdxW-1:0]   byte_idx_q, byte_idx_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;
   logic [DATA_WIDTH-1:0] asm_next;
   logic [7:0]            csum_q, csum_d;
   logic [TmoW-1:0]       tmo_q, tmo_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  load_done_q, load_done_d;
   logic                  load_error_q, load_error_d;
   logic                  in_frame;
   logic                  is_sync;
   logic [16:0]           len_full;

   // Next-state logic for the frame FSM, write port and status flags
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      csum_d       = csum_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      load_done_d  = load_done_q;
      load_error_d = load_error_q;
      cpu_hold_d   = (state_q != StDone);

      in_frame = (state_q == StLenLo) || (state_q == StLenHi) ||
                 (state_q == StData)  || (state_q == StCsum);
      is_sync  = byte_valid_q && (rx_byte_q == SYNC_BYTE);
      len_full = {1'b0, rx_byte_q, len_q[7:0]};
      // Little-endian assembly: each new byte enters at the top and shifts down
      asm_next = DATA_WIDTH'({rx_byte_q, asm_q} >> 8);

      // Idle timer only runs inside a frame and restarts on every received byte
      if (!in_frame || byte_valid_q) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (is_sync) begin
               state_d    = StLenLo;
               len_d      = '0;
               word_cnt_d = '0;
               byte_idx_d = '0;
               asm_d      = '0;
               csum_d     = '0;
            end
         end
         StLenLo: begin
            if (byte_valid_q) begin
               len_d[7:0] = rx_byte_q;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (byte_valid_q) begin
               len_d[15:8] = rx_byte_q;
               if (len_full > MaxWords) begin
                  state_d      = StError;
                  load_error_d = 1'b1;
               end else if (len_full == 17'd0) begin
                  state_d = StCsum;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (byte_valid_q) begin
               asm_d  = asm_next;
               csum_d = csum_q + rx_byte_q;
               if (byte_idx_q == ByteLast) begin
                  byte_idx_d   = '0;
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                  imem_wdata_d = asm_next;
                  word_cnt_d   = word_cnt_q + 1'b1;
                  if ((word_cnt_q + 16'd1) == len_q) begin
                     state_d = StCsum;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
            end
         end
         StCsum: begin
            if (byte_valid_q) begin
               if (rx_byte_q == csum_q) begin
                  state_d     = StDone;
                  load_done_d = 1'b1;
               end else begin
                  state_d      = StError;
                  load_error_d = 1'b1;
               end
            end
         end
         StDone: begin
            // Loaded image stays until reset; further traffic is ignored
         end
         StError: begin
            if (is_sync) begin
               state_d      = StLenLo;
               load_error_d = 1'b0;
               len_d        = '0;
               word_cnt_d   = '0;
               byte_idx_d   = '0;
               asm_d        = '0;
               csum_d       = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Line errors and inter-byte timeouts abort any frame in progress
      if (in_frame && (frame_err_q || (!byte_valid_q && (tmo_q == TmoEnd)))) begin
         state_d      = StError;
         load_error_d = 1'b1;
      end
   end

   // Frame state and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_idx_q   <= '0;
         asm_q        <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_idx_q   <= byte_idx_d;
         asm_q        <= asm_d;
         csum_q       <= csum_d;
         tmo_q        <= tmo_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: small bit period and timeout, imem write monitor,
// one task per scenario with inline expected values.
module tb_uart_imem_loader;

   localparam int unsigned CPB = 4;

   logic        clk;
   logic        reset;
   logic        RsRx;
   logic        imem_we;
   logic [3:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;

   int vectors;
   int miscompares;
   int we_cnt;
   logic [31:0] mem [16];

   uart_imem_loader #(
      .CLKS_PER_BIT(CPB),
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (4),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CLKS(200)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RsRx      (RsRx),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_error(load_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Captures imem writes; cleared while reset is held
   always @(negedge clk) begin
      if (!reset) begin
         we_cnt <= 0;
         for (int i = 0; i < 16; i++) mem[i] <= 32'hDEADBEEF;
      end else if (imem_we === 1'b1) begin
         we_cnt          <= we_cnt + 1;
         mem[imem_addr]  <= imem_wdata;
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      RsRx  = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      RsRx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RsRx = b[i];
         repeat (CPB) @(negedge clk);
      end
      RsRx = stop_bit;
      repeat (CPB) @(negedge clk);
      RsRx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   // Three-instruction program; true mod-256 byte sum is 8'hBB
   task automatic send_prog(input logic [7:0] csum);
      logic [7:0] p [12];
      p = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h70, 8'h00,
            8'hB3, 8'h81, 8'h20, 8'h00};
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 12; i++) send_byte(p[i], 1'b1);
      send_byte(csum, 1'b1);
      repeat (10) @(negedge clk);
   endtask

   task automatic check_prog_words();
      vectors++;
      if (mem[0] !== 32'h00500093) begin
         miscompares++;
         $display("FAIL word0: got %h want 00500093", mem[0]);
      end
      vectors++;
      if (mem[1] !== 32'h00700113) begin
         miscompares++;
         $display("FAIL word1: got %h want 00700113", mem[1]);
      end
      vectors++;
      if (mem[2] !== 32'h002081B3) begin
         miscompares++;
         $display("FAIL word2: got %h want 002081B3", mem[2]);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({imem_we, imem_addr, imem_wdata} !== 37'd0) begin
         miscompares++;
         $display("FAIL reset_wport: got we=%b addr=%h data=%h want 0", imem_we, imem_addr,
                  imem_wdata);
      end
      vectors++;
      if ({cpu_hold, load_done, load_error} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_status: got %b want 100", {cpu_hold, load_done, load_error});
      end
   endtask

   task automatic test_load();
      do_reset();
      send_prog(8'hBB);
      vectors++;
      if (we_cnt !== 3) begin
         miscompares++;
         $display("FAIL load_we_cnt: got %0d want 3", we_cnt);
      end
      check_prog_words();
      vectors++;
      if ({cpu_hold, load_done, load_error} !== 3'b010) begin
         miscompares++;
         $display("FAIL load_status: got %b want 010", {cpu_hold, load_done, load_error});
      end
      // Further traffic after DONE must not write
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      vectors++;
      if (we_cnt !== 3 || load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_sticky: got we_cnt=%0d done=%b want 3 1", we_cnt, load_done);
      end
   endtask

   task automatic test_bad_csum();
      do_reset();
      send_prog(8'hBE);
      vectors++;
      if (we_cnt !== 3) begin
         miscompares++;
         $display("FAIL csum_we_cnt: got %0d want 3", we_cnt);
      end
      check_prog_words();
      vectors++;
      if ({cpu_hold, load_done, load_error} !== 3'b101) begin
         miscompares++;
         $display("FAIL csum_status: got %b want 101", {cpu_hold, load_done, load_error});
      end
   endtask

   task automatic test_len_overflow();
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h00, 1'b1);
      vectors++;
      if (load_error !== 1'b1 || we_cnt !== 0) begin
         miscompares++;
         $display("FAIL len17: got err=%b we_cnt=%0d want 1 0", load_error, we_cnt);
      end
      send_byte(8'hA5, 1'b1);
      vectors++;
      if (load_error !== 1'b0 || cpu_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL sync_clears_err: got err=%b hold=%b want 0 1", load_error, cpu_hold);
      end
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (4) @(negedge clk);
      vectors++;
      if ({cpu_hold, load_done, load_error} !== 3'b010 || we_cnt !== 0) begin
         miscompares++;
         $display("FAIL len0: got status=%b we_cnt=%0d want 010 0",
                  {cpu_hold, load_done, load_error}, we_cnt);
      end
   endtask

   // Full-depth image: 16 words, word i bytes = i, 10+i, 20+i, 30+i (hex)
   task automatic test_max_len();
      logic [7:0] sum;
      sum = 8'h00;
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 4; j++) begin
            send_byte(8'(16 * j + i), 1'b1);
            sum = sum + 8'(16 * j + i);
         end
      end
      send_byte(sum, 1'b1);
      repeat (4) @(negedge clk);
      vectors++;
      if (we_cnt !== 16 || load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL max_len: got we_cnt=%0d done=%b want 16 1", we_cnt, load_done);
      end
      vectors++;
      if (mem[0] !== 32'h30201000 || mem[15] !== 32'h3F2F1F0F) begin
         miscompares++;
         $display("FAIL max_len_words: got %h %h want 30201000 3F2F1F0F", mem[0], mem[15]);
      end
   endtask

   task automatic test_line_errors();
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h50, 1'b0);
      vectors++;
      if ({cpu_hold, load_done, load_error} !== 3'b101 || we_cnt !== 0) begin
         miscompares++;
         $display("FAIL stop_err: got status=%b we_cnt=%0d want 101 0",
                  {cpu_hold, load_done, load_error}, we_cnt);
      end
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h93, 1'b1);
      repeat (140) @(negedge clk);
      vectors++;
      if (load_error !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_early: got err=%b want 0", load_error);
      end
      repeat (110) @(negedge clk);
      vectors++;
      if (load_error !== 1'b1 || load_done !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo: got err=%b done=%b want 1 0", load_error, load_done);
      end
   endtask

   task automatic test_garbage_glitch();
      do_reset();
      send_byte(8'h3C, 1'b1);
      send_byte(8'hFF, 1'b1);
      vectors++;
      if ({cpu_hold, load_done, load_error} !== 3'b100) begin
         miscompares++;
         $display("FAIL garbage: got %b want 100", {cpu_hold, load_done, load_error});
      end
      RsRx = 1'b0;
      @(negedge clk);
      RsRx = 1'b1;
      repeat (12) @(negedge clk);
      RsRx = 1'b0;
      repeat (40) @(negedge clk);
      RsRx = 1'b1;
      repeat (20) @(negedge clk);
      send_prog(8'hBB);
      vectors++;
      if (we_cnt !== 3 || load_done !== 1'b1 || load_error !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_load: got we_cnt=%0d done=%b err=%b want 3 1 0", we_cnt,
                  load_done, load_error);
      end
      check_prog_words();
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h50, 1'b1);
      send_byte(8'h00, 1'b1);
      vectors++;
      if (we_cnt !== 1 || mem[0] !== 32'h00500093) begin
         miscompares++;
         $display("FAIL mid_word0: got we_cnt=%0d w0=%h want 1 00500093", we_cnt, mem[0]);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({imem_we, imem_addr, imem_wdata} !== 37'd0 ||
          {cpu_hold, load_done, load_error} !== 3'b100) begin
         miscompares++;
         $display("FAIL mid_reset: got we=%b addr=%h data=%h status=%b want 0 0 0 100",
                  imem_we, imem_addr, imem_wdata, {cpu_hold, load_done, load_error});
      end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      send_prog(8'hBB);
      vectors++;
      if (we_cnt !== 3 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
         miscompares++;
         $display("FAIL reload: got we_cnt=%0d done=%b hold=%b want 3 1 0", we_cnt,
                  load_done, cpu_hold);
      end
      check_prog_words();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      RsRx        = 1'b1;
      test_reset();
      test_load();
      test_bad_csum();
      test_len_overflow();
      test_max_len();
      test_line_errors();
      test_garbage_glitch();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
